pipe_skid_stage: RTL
====================

# pipe_skid_stage

Parametrised pipeline stage register that replaces the fixed per-stage registers between CPU pipeline stages (E→M, M→W, …) with one generic block. It carries an opaque payload of WIDTH bits with a valid/ready handshake, synchronous flush (bubble insertion), and an optional two-entry skid buffer that registers the upstream ready path. A saturating stall counter provides performance visibility.

## Interface
Parameters:
- WIDTH, 32: payload width in bits; must be ≥ 1.
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
- BUBBLE, {WIDTH{1'b0}}: payload value held when the stage is empty, after reset and after flush.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries and of any same-cycle input.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  WIDTH  head payload; equals BUBBLE when out_valid=0.
- occupancy  out  2  held entries: 0, 1, or 2 (2 only when SKID=1).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.

## Operation
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- States: EMPTY, ONE (main entry valid), TWO (main and skid entries valid; SKID=1 only).
- SKID=1: in_ready = (state != TWO), decoded from registered state only.
  - EMPTY: accept → ONE, main ← in_data.
  - ONE: accept&drain → ONE, main ← in_data. accept&!drain → TWO, skid ← in_data. !accept&drain → EMPTY, main ← BUBBLE. Otherwise hold.
  - TWO: drain → ONE, main ← skid, skid ← BUBBLE. Otherwise hold.
- SKID=0: in_ready = (state==EMPTY) | out_ready. State TWO is unreachable; the skid register is not synthesised.
- Beats leave in arrival order. No beat is duplicated or lost except by flush or reset.
- flush=1, reset=0: next state EMPTY; main and skid ← BUBBLE. An accept in the same cycle is discarded. drain still completes downstream, so the head beat is consumed in that cycle. stall_cnt keeps its value.
- reset=1 has priority over flush and handshakes. Next state EMPTY; main and skid ← BUBBLE; stall_cnt ← 0.
- stall_cnt increments when out_valid & !out_ready, including in flush cycles. It holds at 2^CNT_W−1.

## Timing
- Reset values: out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0. in_ready=1 in the cycle after reset.
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N (one cycle). A beat parked in the skid entry appears at the head one cycle after the draining edge.
- in_valid, in_data, out_ready, and flush are sampled only at the rising edge.
- SKID=1: no combinational path from out_ready to in_ready.
- SKID=0: a combinational path from out_ready to in_ready is required, which gives full throughput with one entry.
- Throughput: one beat per cycle in steady state in both modes.
- Reset asserted mid-stream for one cycle: all entries are dropped. The first post-reset beat is accepted on the next edge.

## Structure
- Shared package pipe_pkg:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - payload-width constants for each stage boundary (e.g. EM_PAYLOAD_W, MW_PAYLOAD_W), so stage instances and packing logic agree.
- One sub-module is natural: sat_counter (parameter W; inputs clk, reset, inc; output count). It is reused by other performance counters.
- Payload packing/unpacking of control bits (RegWrite, MemtoReg, load/store type, link flags) lives at the instantiation site, not in this block.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 → out_data shows 0x11, 0x22, 0x33 on the three following cycles; occupancy stays 1.
- SKID=1: send 0xA, 0xB with out_ready=0 → occupancy=2, in_ready=0. Raise out_ready → 0xA then 0xB, in order; in_ready=1 after the first drain.
- SKID=1, state TWO: assert flush with in_valid=1 (data 0xC) → next cycle occupancy=0, out_valid=0, out_data=BUBBLE; 0xC never appears.
- Hold out_valid=1, out_ready=0 for 5 cycles with CNT_W=2 → stall_cnt reads 1, 2, 3, 3, 3 (saturation).
- SKID=0: out_ready=1 with a continuous input stream → in_ready stays 1 at 100% throughput. Drop out_ready=0 → in_ready falls in the same cycle.
- Assert reset and flush together while occupancy=2 → all outputs return to reset values and stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for generic pipeline stage registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Stage fill state; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Payload widths at each stage boundary, shared by the stage
    // instances and the packing/unpacking logic around them.
    localparam int unsigned EM_PAYLOAD_W = 72;
    localparam int unsigned MW_PAYLOAD_W = 71;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
// Latency: count reflects an inc one cycle after the sampling edge.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports: clk, reset (sync, active-high), inc (count this cycle),
//        count (current value, W bits).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with valid/ready, flush and optional 2-entry skid.
// Latency: one cycle from accepting edge to out_data/out_valid.
// Backpressure: SKID=1 registers in_ready (low only when full); SKID=0 passes out_ready through.
//
// Ports: clk, reset (sync, active-high), flush (kill held + same-cycle beat),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//        (downstream, out_data=BUBBLE when empty), occupancy (0..2),
//        stall_cnt (saturating count of out_valid & !out_ready cycles).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q;
    logic             accept, drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // main_q is forced to BUBBLE whenever the stage empties, so the head
    // payload can be driven straight from the register.
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    // Only reachable with SKID=1: without a skid entry,
                    // accepting in ONE implies out_ready, hence a drain.
                    state_d = ST_TWO;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = BUBBLE;
            end
        endcase
        // Flush drops everything held and any same-cycle accept; a drain in
        // the same cycle has already been taken downstream.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends only on registered state: no out_ready->in_ready path.
            assign in_ready = (state_q != ST_TWO);

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    skid_q <= BUBBLE;
                end else if ((state_q == ST_ONE) && accept && !drain) begin
                    skid_q <= in_data;
                end else if ((state_q == ST_TWO) && drain) begin
                    skid_q <= BUBBLE;
                end
            end
        end else begin : g_noskid
            // Single entry at full throughput needs the downstream ready
            // passed straight through.
            assign in_ready = (state_q == ST_EMPTY) | out_ready;
            assign skid_q   = BUBBLE;
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule
